div4_restoring: RTL and testbench

- Sequential unsigned restoring divider, built as the subtractive counterpart of the team's 4-bit lookahead adder.
- Computes quotient and remainder by trial subtraction, one quotient bit per clock.
- Single-operation start/done handshake; sits beside the adder blocks in the arithmetic examples.
- Default width is 4 bits, matching the adder's 4-bit operands.

---
 rtl/div4_restoring.sv | 150 +++++++++++++++
 tb/tb_div4_restoring.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/div4_restoring.sv
// ---------------------------------------------------------------------------
// div4_restoring
//
// Sequential unsigned restoring divider. It is the subtractive counterpart of
// the 4-bit lookahead adder. It produces one quotient bit per clock by trial
// subtraction. Operation uses a single start/done handshake.
//
// Parameters:
//   WIDTH        operand/result width and iteration count (legal 2..8)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (priority over all inputs)
//   start        operation request, sampled only in IDLE
//   dividend     unsigned dividend, sampled on the accepting edge
//   divisor      unsigned divisor, sampled on the accepting edge
//   busy         high while iterating (RUN state)
//   done         one-cycle pulse, high while results first become valid
//   quotient     result quotient, held until the next completed operation
//   remainder    result remainder, held until the next completed operation
//   div_by_zero  set with done when divisor == 0, cleared on next accept
//
// Optional feature (macro DIV_EARLY_EXIT_EN):
//   When defined, an accepted operation with divisor != 0 and
//   dividend < divisor skips the iterations. It goes straight to DONE with
//   quotient = 0 and remainder = dividend. Results match the default build;
//   only the latency differs.
// ---------------------------------------------------------------------------
module div4_restoring #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int            CW         = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH:0]   r_rem;        // partial remainder, one guard bit wide
    logic [WIDTH-1:0] r_q;          // dividend bits shifting out, quotient bits in
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [2*WIDTH:0] w_shift;
    logic [WIDTH:0]   w_rshift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last;
    logic             w_short_path;

    // One restoring step: shift {R,Q} left, then trial-subtract the divisor.
    // The partial remainder is always below the divisor. So the shifted value
    // fits in WIDTH+1 bits, and the MSB of the trial difference is a clean
    // borrow flag.
    assign w_shift    = {r_rem, r_q} << 1;
    assign w_rshift   = w_shift[2*WIDTH:WIDTH];
    assign w_trial    = w_rshift - {1'b0, r_divisor};
    assign w_fits     = ~w_trial[WIDTH];
    assign w_rem_next = w_fits ? w_trial : w_rshift;
    assign w_q_next   = w_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, w_fits};
    assign w_last     = (r_count == '0);

    // Accepted operations whose result is known without iterating.
`ifdef DIV_EARLY_EXIT_EN
    assign w_short_path = (divisor == '0) || (dividend < divisor);
`else
    assign w_short_path = (divisor == '0);
`endif

    // NOTE: all state below is written with non-blocking assignments, so
    // every branch reads the pre-edge values of r_rem/r_q/r_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_divisor <= divisor;
                        r_q       <= dividend;
                        r_rem     <= '0;
                        r_count   <= LAST_COUNT;
                        if (w_short_path) begin
                            // Divide by zero reports all-ones. A dividend
                            // smaller than the divisor gives quotient 0.
                            // In both cases the remainder is the dividend.
                            r_state     <= S_DONE;
                            r_quotient  <= (divisor == '0) ? {WIDTH{1'b1}} : '0;
                            r_remainder <= dividend;
                            r_dbz       <= (divisor == '0);
                        end else begin
                            r_state <= S_RUN;
                            r_dbz   <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_rem   <= w_rem_next;
                    r_q     <= w_q_next;
                    r_count <= r_count - CW'(1);
                    if (w_last) begin
                        // Results are captured on the edge entering DONE,
                        // so they become valid together with done.
                        r_state     <= S_DONE;
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next[WIDTH-1:0];
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div4_restoring.sv
// ---------------------------------------------------------------------------
// tb_div4_restoring
//
// Self-checking bench for div4_restoring. Expected results come from plain
// integer division. Expected timing comes from the operation class:
//   - normal: done WIDTH edges after the accepting edge, busy for WIDTH cycles
//   - short (divisor 0, or dividend < divisor with DIV_EARLY_EXIT_EN):
//     done in the cycle right after the accepting edge, no busy
// ---------------------------------------------------------------------------
module tb_div4_restoring;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    div4_restoring #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: results and latency (edges after the accepting edge).
    function automatic void model(input int a, input int b, output int q,
                                  output int r, output int dbz, output int lat);
        if (b == 0) begin
            q = MASK; r = a; dbz = 1; lat = 0;
        end else begin
            q = a / b; r = a % b; dbz = 0; lat = W;
`ifdef DIV_EARLY_EXIT_EN
            if (a < b) lat = 0;
`endif
        end
    endfunction

    // Issue one operation and watch the following W+3 cycles. If repulse >= 0,
    // a one-cycle start for 8/2 is injected at that cycle index, and it must
    // be ignored.
    task automatic run_op(input int a, input int b, input int repulse, input string tag);
        int q, r, dbz, lat;
        int done_at, done_n, busy_n;
        int got_q, got_r, got_z;
        model(a, b, q, r, dbz, lat);
        @(negedge clk);
        start = 1'b1; dividend = W'(a); divisor = W'(b);
        @(posedge clk);              // accepting edge
        done_at = -1; done_n = 0; busy_n = 0;
        got_q = -1; got_r = -1; got_z = -1;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = i;
                    got_q = int'(quotient);
                    got_r = int'(remainder);
                    got_z = int'(div_by_zero);
                end
            end
            if (i == 0) begin
                // Operand changes after acceptance must not matter.
                start    = 1'b0;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            if (i == repulse) begin
                start = 1'b1; dividend = 4'd8; divisor = 4'd2;
            end else if (repulse >= 0 && i == repulse + 1) begin
                start = 1'b0;
            end
        end
        check({tag, "_lat"}, done_at, lat);
        check({tag, "_ndone"}, done_n, 1);
        check({tag, "_busy"}, busy_n, lat);
        check({tag, "_q"}, got_q, q);
        check({tag, "_r"}, got_r, r);
        check({tag, "_dbz"}, got_z, dbz);
        check({tag, "_hold_q"}, int'(quotient), q);
    endtask

    initial begin
        int q, r, dbz, lat;
        int seen, k, cyc, prev;
        logic [2*W-1:0] pair;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(quotient), 0);
        check("rst_r", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        rst = 1'b0;

        run_op(13, 3, -1, "d13_3");
        run_op(15, 1, -1, "d15_1");
        run_op(15, 15, -1, "d15_15");
        run_op(7, 0, -1, "d7_0");
        run_op(9, 2, -1, "d9_2");
        run_op(2, 9, -1, "d2_9");
        run_op(13, 3, 1, "repulse");

        // Reset in the middle of a 12/5 operation: rst is sampled at the
        // second RUN edge (edge 2 after acceptance).
        @(negedge clk);
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(posedge clk);
        @(negedge clk); start = 1'b0;   // after edge 0
        @(negedge clk); rst = 1'b1;     // after edge 1
        @(negedge clk);                 // after edge 2 (reset applied)
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_q", int'(quotient), 0);
        check("midrst_r", int'(remainder), 0);
        check("midrst_dbz", int'(div_by_zero), 0);
        rst = 1'b0;
        seen = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("midrst_idle", seen, 0);

        for (int n = 0; n < 16; n++) begin
            run_op(int'($urandom_range(MASK, 0)), int'($urandom_range(MASK, 0)), -1, "rand");
        end

        // Exhaustive sweep with start held high. The next operands are
        // presented as soon as done is seen. The DONE->IDLE edge ignores
        // them, and the edge after that accepts them.
        @(negedge clk);
        k = 0; cyc = 0; prev = -1;
        pair = '0;
        dividend = pair[2*W-1:W]; divisor = pair[W-1:0];
        start = 1'b1;
        while (k < (1 << (2 * W)) && cyc < (1 << (2 * W)) * (W + 2) + 50) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                pair = (2*W)'(k);
                model(int'(pair[2*W-1:W]), int'(pair[W-1:0]), q, r, dbz, lat);
                check("sweep_q", int'(quotient), q);
                check("sweep_r", int'(remainder), r);
                check("sweep_dbz", int'(div_by_zero), dbz);
                if (prev >= 0) check("sweep_gap", cyc - prev, lat + 2);
                prev = cyc;
                k++;
                pair = (2*W)'(k);
                dividend = pair[2*W-1:W];
                divisor  = pair[W-1:0];
            end
        end
        start = 1'b0;
        check("sweep_count", k, 1 << (2 * W));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
